// File: rtl/alarm_scheduler.sv
// Three one-shot alarm slots compared against the running clock; sequences
// ring, snooze and stop for the active alarm and queues simultaneous matches.
module alarm_scheduler #(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] hour1,
  input  logic [4:0] hour2,
  input  logic [4:0] hour3,
  input  logic [5:0] min1,
  input  logic [5:0] min2,
  input  logic [5:0] min3,
  input  logic [5:0] sec1,
  input  logic [5:0] sec2,
  input  logic [5:0] sec3,
  input  logic       set1,
  input  logic       set2,
  input  logic       set3,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       ring,
  output logic [1:0] ring_id,
  output logic       snoozing,
  output logic [2:0] armed,
  output logic [2:0] pending
);

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [4:0]    hour_r [3];
  logic [5:0]    min_r  [3];
  logic [5:0]    sec_r  [3];
  logic [2:0]    armed_r;
  logic [2:0]    pending_r;
  logic          ring_r;
  logic          snoozing_r;
  logic [1:0]    ring_id_r;

  logic [4:0]    in_hour_s [3];
  logic [5:0]    in_min_s  [3];
  logic [5:0]    in_sec_s  [3];
  logic [2:0]    set_s;
  logic [2:0]    valid_s;
  logic [2:0]    match_s;
  logic [2:0]    pend_base_s;
  logic [2:0]    pend_next_s;
  logic [1:0]    start_id_s;
  logic          abort_s;
  logic          cnt_last_s;
  logic [CW-1:0] cnt_dec_s;

  function automatic logic [1:0] lowest_id(input logic [2:0] v);
    if (v[0]) begin
      return 2'd1;
    end else if (v[1]) begin
      return 2'd2;
    end else if (v[2]) begin
      return 2'd3;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Slot matching, load validation, pending bookkeeping and counter helpers
  always_comb begin
    set_s        = {set3, set2, set1};
    in_hour_s[0] = hour1;
    in_hour_s[1] = hour2;
    in_hour_s[2] = hour3;
    in_min_s[0]  = min1;
    in_min_s[1]  = min2;
    in_min_s[2]  = min3;
    in_sec_s[0]  = sec1;
    in_sec_s[1]  = sec2;
    in_sec_s[2]  = sec3;
    valid_s      = 3'b000;
    match_s      = 3'b000;
    abort_s      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_s[i] = (in_hour_s[i] <= 5'd23) && (in_min_s[i] <= 6'd59) && (in_sec_s[i] <= 6'd59);
      // A reload in the same cycle supersedes the old time in that slot
      match_s[i] = tick_1hz && armed_r[i] && !set_s[i] && (hour_r[i] == cur_hour) &&
                   (min_r[i] == cur_min) && (sec_r[i] == cur_sec);
      if ((state_r != IDLE) && set_s[i] && (ring_id_r == 2'(i + 1))) begin
        abort_s = 1'b1;
      end else begin
        abort_s = abort_s;
      end
    end
    pend_base_s = pending_r & ~set_s;
    if (match_s != 3'b000) begin
      start_id_s = lowest_id(match_s);
    end else begin
      start_id_s = lowest_id(pend_base_s);
    end
    if (state_r == IDLE) begin
      pend_next_s = (pend_base_s | match_s) & ~id_mask(start_id_s);
    end else begin
      pend_next_s = pend_base_s | match_s;
    end
    cnt_last_s = (cnt_r == CW'(1));
    if (cnt_r > CW'(1)) begin
      cnt_dec_s = cnt_r - CW'(1);
    end else begin
      cnt_dec_s = cnt_r;
    end
  end

  // Slot storage, arming and the ring/snooze state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      armed_r    <= 3'b000;
      pending_r  <= 3'b000;
      ring_r     <= 1'b0;
      snoozing_r <= 1'b0;
      ring_id_r  <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        hour_r[i] <= 5'd0;
        min_r[i]  <= 6'd0;
        sec_r[i]  <= 6'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (set_s[i] && valid_s[i]) begin
          hour_r[i]  <= in_hour_s[i];
          min_r[i]   <= in_min_s[i];
          sec_r[i]   <= in_sec_s[i];
          armed_r[i] <= 1'b1;
        end else if (set_s[i] || match_s[i]) begin
          armed_r[i] <= 1'b0;
        end
      end
      pending_r <= pend_next_s;
      case (state_r)
        IDLE: begin
          if (start_id_s != 2'd0) begin
            state_r   <= RING;
            ring_r    <= 1'b1;
            ring_id_r <= start_id_s;
            cnt_r     <= CW'(RING_SECS);
          end
        end
        RING: begin
          if (abort_s || stop_btn || (tick_1hz && cnt_last_s)) begin
            state_r   <= IDLE;
            ring_r    <= 1'b0;
            ring_id_r <= 2'd0;
          end else if (snooze_btn) begin
            state_r    <= SNOOZE;
            ring_r     <= 1'b0;
            snoozing_r <= 1'b1;
            cnt_r      <= CW'(SNOOZE_SECS);
          end else if (tick_1hz) begin
            cnt_r <= cnt_dec_s;
          end
        end
        SNOOZE: begin
          if (abort_s || stop_btn) begin
            state_r    <= IDLE;
            snoozing_r <= 1'b0;
            ring_id_r  <= 2'd0;
          end else if (tick_1hz && cnt_last_s) begin
            state_r    <= RING;
            ring_r     <= 1'b1;
            snoozing_r <= 1'b0;
            cnt_r      <= CW'(RING_SECS);
          end else if (tick_1hz) begin
            cnt_r <= cnt_dec_s;
          end
        end
        default: begin
          state_r    <= IDLE;
          ring_r     <= 1'b0;
          snoozing_r <= 1'b0;
          ring_id_r  <= 2'd0;
        end
      endcase
    end
  end

  assign ring     = ring_r;
  assign ring_id  = ring_id_r;
  assign snoozing = snoozing_r;
  assign armed    = armed_r;
  assign pending  = pending_r;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Table-driven bench for alarm_scheduler (RING_SECS=3, SNOOZE_SECS=2) with a
// queue of expected outputs and a hand-written asynchronous reset sequence.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] hour1, hour2, hour3;
  logic [5:0] min1, min2, min3, sec1, sec2, sec3;
  logic       set1, set2, set3, stop_btn, snooze_btn;
  logic       ring, snoozing;
  logic [1:0] ring_id;
  logic [2:0] armed, pending;

  typedef struct {
    logic       tick;
    logic [4:0] ch;
    logic [5:0] cm, cs;
    logic [2:0] setm;
    logic [4:0] sh;
    logic [5:0] sm, ss;
    logic       stop, snz;
    logic       ering;
    logic [1:0] eid;
    logic       esnz;
    logic [2:0] earm, epend;
  } vec_t;

  typedef struct packed {
    logic       ring;
    logic [1:0] id;
    logic       snz;
    logic [2:0] arm;
    logic [2:0] pend;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  alarm_scheduler #(.RING_SECS(3), .SNOOZE_SECS(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hour1(hour1), .hour2(hour2), .hour3(hour3),
    .min1(min1), .min2(min2), .min3(min3),
    .sec1(sec1), .sec2(sec2), .sec3(sec3),
    .set1(set1), .set2(set2), .set3(set3),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .ring(ring), .ring_id(ring_id), .snoozing(snoozing),
    .armed(armed), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic tk, input int ch, input int cm, input int cs,
                              input logic [2:0] setm, input int sh, input int sm, input int ss,
                              input logic stp, input logic snz, input logic er, input int eid,
                              input logic es, input logic [2:0] ea, input logic [2:0] ep);
    vec_t v;
    v.tick = tk;   v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
    v.setm = setm; v.sh = 5'(sh); v.sm = 6'(sm); v.ss = 6'(ss);
    v.stop = stp;  v.snz = snz;
    v.ering = er;  v.eid = 2'(eid); v.esnz = es; v.earm = ea; v.epend = ep;
    return v;
  endfunction

  task automatic check_outs(input string name, input exp_t want);
    total++;
    if ({ring, ring_id, snoozing, armed, pending} === {want.ring, want.id, want.snz, want.arm, want.pend}) begin
      passed++;
    end else begin
      $display("FAIL %s: got ring=%0b id=%0d snz=%0b armed=%03b pend=%03b, want ring=%0b id=%0d snz=%0b armed=%03b pend=%03b",
               name, ring, ring_id, snoozing, armed, pending,
               want.ring, want.id, want.snz, want.arm, want.pend);
    end
  endtask

  task automatic drive_idle();
    tick_1hz = 1'b0; cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
    hour1 = 5'd0; hour2 = 5'd0; hour3 = 5'd0;
    min1 = 6'd0; min2 = 6'd0; min3 = 6'd0; sec1 = 6'd0; sec2 = 6'd0; sec3 = 6'd0;
    set1 = 1'b0; set2 = 1'b0; set3 = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    @(negedge clk);
    tick_1hz = v.tick; cur_hour = v.ch; cur_min = v.cm; cur_sec = v.cs;
    hour1 = v.sh; hour2 = v.sh; hour3 = v.sh;
    min1 = v.sm; min2 = v.sm; min3 = v.sm;
    sec1 = v.ss; sec2 = v.ss; sec3 = v.ss;
    set1 = v.setm[0]; set2 = v.setm[1]; set3 = v.setm[2];
    stop_btn = v.stop; snooze_btn = v.snz;
    e.ring = v.ering; e.id = v.eid; e.snz = v.esnz; e.arm = v.earm; e.pend = v.epend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_outs(name, got);
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    //              tk ch cm cs  setm   sh sm ss stp snz  er id es arm     pend
    // alarm 1 at 07:30:00, rings for exactly three ticks
    vecs.push_back(mk(0, 0, 0, 0, 3'b001, 7,30, 0, 0, 0,  0, 0, 0, 3'b001, 3'b000));
    vecs.push_back(mk(1, 7,29,59, 3'b000, 0, 0, 0, 0, 0,  0, 0, 0, 3'b001, 3'b000));
    vecs.push_back(mk(1, 7,30, 0, 3'b000, 0, 0, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 7,30, 1, 3'b000, 0, 0, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 7,30, 2, 3'b000, 0, 0, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 7,30, 3, 3'b000, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
    // alarm 2 snooze, re-ring, snooze ignored while snoozing, stop with tick
    vecs.push_back(mk(0, 0, 0, 0, 3'b010, 8, 0, 0, 0, 0,  0, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 8, 0, 0, 3'b000, 0, 0, 0, 0, 0,  1, 2, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1,  0, 2, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 8, 0, 1, 3'b000, 0, 0, 0, 0, 0,  0, 2, 1, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1,  0, 2, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 8, 0, 2, 3'b000, 0, 0, 0, 0, 0,  1, 2, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 8, 0, 3, 3'b000, 0, 0, 0, 1, 0,  0, 0, 0, 3'b000, 3'b000));
    // alarms 1 and 3 together: 1 rings, 3 pends, then dispatches after stop
    vecs.push_back(mk(0, 0, 0, 0, 3'b101,12, 0, 0, 0, 0,  0, 0, 0, 3'b101, 3'b000));
    vecs.push_back(mk(1,12, 0, 0, 3'b000, 0, 0, 0, 0, 0,  1, 1, 0, 3'b000, 3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0,  0, 0, 0, 3'b000, 3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0,  1, 3, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0,  0, 0, 0, 3'b000, 3'b000));
    // out-of-range loads disarm; disarmed slot never rings
    vecs.push_back(mk(0, 0, 0, 0, 3'b010, 9, 0, 0, 0, 0,  0, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b010,24, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b100, 5, 0, 0, 0, 0,  0, 0, 0, 3'b100, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b100, 5,60, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 9, 0, 0, 3'b000, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 5, 0, 0, 3'b000, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
    // reload of the ringing alarm aborts it and arms the new time
    vecs.push_back(mk(0, 0, 0, 0, 3'b010,10, 0, 0, 0, 0,  0, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1,10, 0, 0, 3'b000, 0, 0, 0, 0, 0,  1, 2, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 3'b010,10, 0, 5, 0, 0,  0, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1,10, 0, 5, 3'b000, 0, 0, 0, 0, 0,  1, 2, 0, 3'b000, 3'b000));
    // snooze while arming alarm 1, whose match then pends
    vecs.push_back(mk(0, 0, 0, 0, 3'b001,11, 0, 0, 0, 1,  0, 2, 1, 3'b001, 3'b000));
    vecs.push_back(mk(1,11, 0, 0, 3'b000, 0, 0, 0, 0, 0,  0, 2, 1, 3'b000, 3'b001));

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_state", zero);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset mid-SNOOZE, checked before any clock edge
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", zero);
    @(negedge clk);
    rst_n = 1'b1;

    // old alarm times must not ring after reset
    run_vec(mk(1,11, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000), "post_reset_a");
    run_vec(mk(1,10, 0, 5, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000), "post_reset_b");
    run_vec(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000), "post_reset_c");

    @(negedge clk);
    drive_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
